// File: rtl/mult_div_pkg.sv
// Shared encodings and defaults for the iterative signed multiply/divide engine.
package mult_div_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MULT = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on a double-width accumulator.
module mult_div_step
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  op_e                op,
  output logic [2*WIDTH-1:0] acc_next
);

  localparam int unsigned ACC_W = 2 * WIDTH;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [ACC_W-1:0] shl;

  // MULT: acc = {partial product, remaining multiplier bits}; DIV: acc = {rem, quo}.
  always_comb begin
    sum      = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    shl      = {acc[ACC_W-2:0], 1'b0};
    diff     = acc[ACC_W-1:WIDTH-1] - {1'b0, operand};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (op == OP_DIV) begin
      acc_next = diff[WIDTH] ? shl : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Sequencing FSM, operand latch, sign handling and HI/LO ownership for the multiply/divide engine.
module mult_div_sequencer
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hi_lo_w,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_d, done_d, div_zero_d, hi_lo_w_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [ACC_W-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Magnitudes; the most negative value maps onto itself as an unsigned number.
  assign mag_a    = a_q[WIDTH-1] ? (~a_q + WIDTH'(1)) : a_q;
  assign mag_b    = b_q[WIDTH-1] ? (~b_q + WIDTH'(1)) : b_q;
  assign prod_fix = neg_res_q ? (~acc_q + ACC_W'(1)) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];

  mult_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc_q),
    .operand (operand_q),
    .op      (op_q),
    .acc_next(acc_step)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy;
    done_d     = 1'b0;
    div_zero_d = div_zero;
    hi_lo_w_d  = 1'b0;
    hi_d       = hi_out;
    lo_d       = lo_out;

    case (state_q)
      S_IDLE: begin
        div_zero_d = 1'b0;
        if (start && op_valid(op)) begin
          op_d    = op_e'(op);
          a_d     = src_a;
          b_d     = src_b;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if ((op_q == OP_DIV) && (b_q == '0)) begin
          done_d     = 1'b1;
          div_zero_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          neg_res_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
          neg_rem_d = a_q[WIDTH-1];
          // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
          acc_d     = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          operand_d = (op_q == OP_DIV) ? mag_b : mag_a;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        acc_d = acc_step;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FIX: begin
        if (op_q == OP_DIV) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[ACC_W-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d    = 1'b1;
        hi_lo_w_d = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE: begin
        busy_d     = 1'b0;
        div_zero_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        busy_d     = 1'b0;
        div_zero_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NONE;
      a_q       <= '0;
      b_q       <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi_lo_w   <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= div_zero_d;
      hi_lo_w   <= hi_lo_w_d;
      hi_out    <= hi_d;
      lo_out    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench: directed corner cases plus random MULT/DIV against a signed-arithmetic model.
module tb_mult_div_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_in;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, div_zero, hi_lo_w;
  logic [W-1:0] hi_out, lo_out;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          done_seen = 0;
  int          wr_seen = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] corners [8];

  mult_div_sequencer dut (
    .clk     (clk),
    .reset_in(reset_in),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi_lo_w (hi_lo_w),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen++;
    if (hi_lo_w) wr_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, truncating division.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output bit dz, output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = exp_hi;
    lo = exp_lo;
    if (o == 2'b01) begin
      p  = sa * sb;
      pv = p;
      hi = pv[63:32];
      lo = pv[31:0];
    end else if (sb == 0) begin
      dz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      pv = q;
      lo = pv[31:0];
      pv = r;
      hi = pv[31:0];
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    bit dz;
    logic [31:0] ehi, elo;
    int lat, k_done, d0, w0;
    model(o, a, b, dz, ehi, elo);
    lat = dz ? 1 : 34;
    d0 = done_seen;
    w0 = wr_seen;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom; op = 2'($urandom);
    chk("busy_accept", busy, 1);
    k_done = -1;
    for (int k = 0; k <= 40; k++) begin
      if (done) begin
        k_done = k;
        break;
      end
      if (poke) begin
        start = (k == 4);
        op = 2'b01;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_latency", 64'(k_done), 64'(lat));
    chk("busy_at_done", busy, 1);
    chk("div_zero", div_zero, dz);
    chk("hi_lo_w", hi_lo_w, !dz);
    chk("hi_out", hi_out, ehi);
    chk("lo_out", lo_out, elo);
    exp_hi = ehi;
    exp_lo = elo;
    @(posedge clk); #1;
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("hi_hold", hi_out, exp_hi);
    chk("lo_hold", lo_out, exp_lo);
    if (poke) repeat (40) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_seen - d0), 1);
    chk("write_pulses", 64'(wr_seen - w0), dz ? 0 : 1);
  endtask

  task automatic run_bad(input logic [1:0] o);
    int d0;
    d0 = done_seen;
    op = o; src_a = $urandom; src_b = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_op_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("bad_op_done", 64'(done_seen - d0), 0);
  endtask

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    int d0, w0;
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h12345678};
    reset_in = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_hi_lo_w", hi_lo_w, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    reset_in = 1'b0;

    run_op(2'b01, 32'd7, 32'hFFFFFFFD, 0);
    chk("mul_neg_hi", hi_out, 32'hFFFFFFFF);
    chk("mul_neg_lo", lo_out, 32'hFFFFFFEB);
    run_op(2'b01, 32'h80000000, 32'h80000000, 0);
    chk("mul_min_hi", hi_out, 32'h40000000);
    chk("mul_min_lo", lo_out, 32'h00000000);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("mul_m1_hi", hi_out, 32'h0);
    chk("mul_m1_lo", lo_out, 32'h1);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_neg_lo", lo_out, 32'hFFFFFFFD);
    chk("div_neg_hi", hi_out, 32'hFFFFFFFF);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf_lo", lo_out, 32'h80000000);
    chk("div_ovf_hi", hi_out, 32'h0);

    // Preload HI/LO with a product, then divide by zero must leave them untouched.
    run_op(2'b01, 32'h55555556, 32'h33333333, 0);
    chk("preload_hi", hi_out, 32'h11111111);
    chk("preload_lo", lo_out, 32'h22222222);
    run_op(2'b10, 32'd5, 32'd0, 0);
    chk("dz_hi", hi_out, 32'h11111111);
    chk("dz_lo", lo_out, 32'h22222222);

    run_op(2'b01, 32'd1000, 32'hFFFFFF9C, 1);
    run_bad(2'b00);
    run_bad(2'b11);

    for (int i = 0; i < 16; i++) begin
      run_op(($urandom_range(0, 9) < 5) ? 2'b01 : 2'b10, pick(), pick(), 0);
    end

    // Reset in the middle of RUN.
    d0 = done_seen;
    w0 = wr_seen;
    op = 2'b01; src_a = 32'h1234; src_b = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_in = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi_out, 0);
    chk("midrst_lo", lo_out, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_seen - d0), 0);
    chk("midrst_no_write", 64'(wr_seen - w0), 0);

    // Reset together with start drops the request.
    d0 = done_seen;
    op = 2'b10; src_a = 32'd9; src_b = 32'd0; start = 1'b1; reset_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset_in = 1'b0;
    chk("rststart_busy", busy, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("rststart_no_done", 64'(done_seen - d0), 0);

    run_op(2'b10, 32'd100, 32'hFFFFFFF9, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
